// File: rtl/audio_clock_divider.sv
// AD1939 serial-port clock generator: divides the 98.304 MHz PLL clock into bclk/lrclk with
// edge strobes, started after a lock-settle window and stopped on enable drop or lock loss.
module audio_clock_divider #(
  parameter int BCLK_DIV       = 32,
  parameter int BITS_PER_FRAME = 64,
  parameter int LOCK_HOLD      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       enable,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_rise,
  output logic       bclk_fall,
  output logic       frame_start,
  output logic       active,
  output logic [7:0] lock_loss_count
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int BIT_W  = $clog2(BITS_PER_FRAME);
  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_HALF  = BIT_W'(BITS_PER_FRAME / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_SETTLE    = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_STOPPING  = 2'd3;

  logic              r_sync1;
  logic              r_lock_s;
  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_bclk;
  logic              r_lrclk;
  logic              r_bclk_rise;
  logic              r_bclk_fall;
  logic              r_frame_start;
  logic              r_active;
  logic [7:0]        r_lock_loss_cnt;

  logic             w_div_mid;
  logic             w_div_wrap;
  logic             w_bit_wrap;
  logic             w_frame_end;
  logic [BIT_W-1:0] w_bit_next;

  assign w_div_mid   = (r_div_cnt == DIV_HALF);
  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_bit_wrap  = (r_bit_cnt == BIT_LAST);
  assign w_frame_end = w_div_wrap && w_bit_wrap;
  assign w_bit_next  = w_bit_wrap ? '0 : r_bit_cnt + BIT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1         <= 1'b0;
      r_lock_s        <= 1'b0;
      r_state         <= S_WAIT_LOCK;
      r_hold_cnt      <= '0;
      r_div_cnt       <= '0;
      r_bit_cnt       <= '0;
      r_bclk          <= 1'b0;
      r_lrclk         <= 1'b0;
      r_bclk_rise     <= 1'b0;
      r_bclk_fall     <= 1'b0;
      r_frame_start   <= 1'b0;
      r_active        <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_sync1       <= pll_locked;
      r_lock_s      <= r_sync1;
      r_bclk_rise   <= 1'b0;
      r_bclk_fall   <= 1'b0;
      r_frame_start <= 1'b0;
      case (r_state)
        S_SETTLE: begin
          if (!r_lock_s) begin
            r_state    <= S_WAIT_LOCK;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            // Hold stays saturated here until enable arrives.
            if (enable) begin
              r_state       <= S_RUN;
              r_div_cnt     <= '0;
              r_bit_cnt     <= '0;
              r_bclk        <= 1'b0;
              r_lrclk       <= 1'b0;
              r_frame_start <= 1'b1;
              r_active      <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN, S_STOPPING: begin
          if (!r_lock_s) begin
            // Abrupt stop: the truncated bclk phase is tolerated, the codec is re-initialised.
            r_state    <= S_WAIT_LOCK;
            r_hold_cnt <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_active   <= 1'b0;
            if (r_lock_loss_cnt != 8'hFF) begin
              r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
            end
          end else if ((r_state == S_STOPPING) && !enable && w_frame_end) begin
            r_state    <= S_SETTLE;
            r_hold_cnt <= HOLD_LAST;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_active   <= 1'b0;
          end else begin
            r_state   <= enable ? S_RUN : S_STOPPING;
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
            if (w_div_mid) begin
              r_bclk      <= 1'b1;
              r_bclk_rise <= 1'b1;
            end
            if (w_div_wrap) begin
              r_bclk        <= 1'b0;
              r_bclk_fall   <= 1'b1;
              r_bit_cnt     <= w_bit_next;
              r_lrclk       <= (w_bit_next >= BIT_HALF);
              r_frame_start <= w_bit_wrap;
            end
          end
        end
        default: begin
          r_hold_cnt <= '0;
          if (r_lock_s) begin
            r_state <= S_SETTLE;
          end
        end
      endcase
    end
  end

  assign bclk            = r_bclk;
  assign lrclk           = r_lrclk;
  assign bclk_rise       = r_bclk_rise;
  assign bclk_fall       = r_bclk_fall;
  assign frame_start     = r_frame_start;
  assign active          = r_active;
  assign lock_loss_count = r_lock_loss_cnt;

endmodule

// File: tb/tb_audio_clock_divider.sv
// Bench for audio_clock_divider: a small-parameter instance checked cycle by cycle against an
// analytic waveform scoreboard, and a default-parameter instance checked by period/pulse counts.
module tb_audio_clock_divider;

  localparam int D     = 4;
  localparam int B     = 8;
  localparam int H     = 5;
  localparam int FRAME = D * B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pll_locked, enable;
  logic       bclk, lrclk, bclk_rise, bclk_fall, frame_start, active;
  logic [7:0] lock_loss_count;

  logic       rst_d, locked_d, enable_d;
  logic       bclk_d, lrclk_d, rise_d, fall_d, fs_d, active_d;
  logic [7:0] llc_d;

  audio_clock_divider #(.BCLK_DIV(D), .BITS_PER_FRAME(B), .LOCK_HOLD(H)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .enable          (enable),
    .bclk            (bclk),
    .lrclk           (lrclk),
    .bclk_rise       (bclk_rise),
    .bclk_fall       (bclk_fall),
    .frame_start     (frame_start),
    .active          (active),
    .lock_loss_count (lock_loss_count)
  );

  audio_clock_divider u_dut_def (
    .clk             (clk),
    .rst             (rst_d),
    .pll_locked      (locked_d),
    .enable          (enable_d),
    .bclk            (bclk_d),
    .lrclk           (lrclk_d),
    .bclk_rise       (rise_d),
    .bclk_fall       (fall_d),
    .frame_start     (fs_d),
    .active          (active_d),
    .lock_loss_count (llc_d)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          k_run    = 0;
  logic [7:0]  exp_llc  = 8'd0;
  logic [13:0] sb_q[$];
  logic [13:0] mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] obs_vec();
    return {bclk, lrclk, bclk_rise, bclk_fall, frame_start, active, lock_loss_count};
  endfunction

  // Expected outputs k cycles after RUN entry, written directly from the waveform definition.
  function automatic logic [13:0] exp_run(input int k);
    int   ph, bitn;
    logic b, lr, r, f, fs;
    ph   = k % D;
    bitn = (k / D) % B;
    b    = (ph >= D / 2);
    r    = (ph == D / 2);
    f    = (ph == 0) && (k > 0);
    lr   = (bitn >= B / 2);
    fs   = ((k % FRAME) == 0);
    return {b, lr, r, f, fs, 1'b1, exp_llc};
  endfunction

  function automatic logic [13:0] exp_idle();
    return {6'b0, exp_llc};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      check_eq($sformatf("outputs@cyc%0d", cyc), {18'b0, obs_vec()}, {18'b0, mon_exp});
    end
  end

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_run(k_run));
      k_run++;
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_idle());
      @(negedge clk);
    end
  endtask

  // From WAIT_LOCK with lock low: 2 sync + 1 entry + LOCK_HOLD settle cycles, then RUN.
  task automatic lock_and_start();
    pll_locked = 1'b1;
    idle_cycles(2 + H);
    k_run = 0;
  endtask

  task automatic lose_lock();
    pll_locked = 1'b0;
    run_cycles(2);
    if (exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
    idle_cycles(3);
  endtask

  int n_rise, n_fs, n_high, both, r1, r2, l1, l2, fs2;
  logic prev_lr, early;

  initial begin
    rst = 1'b1; pll_locked = 1'b0; enable = 1'b1;
    rst_d = 1'b1; locked_d = 1'b0; enable_d = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {18'b0, obs_vec()}, 32'd0);
    rst = 1'b0;
    idle_cycles(4);
    $display("phase reset: checks=%0d", checks);

    lock_and_start();
    run_cycles(2 * FRAME);
    $display("phase startup: checks=%0d", checks);

    // enable drop at bit 2, back at bit 5: the frame continues unbroken
    run_cycles(8);
    enable = 1'b0;
    run_cycles(12);
    enable = 1'b1;
    run_cycles(FRAME - 20 + FRAME);
    $display("phase reraise: checks=%0d", checks);

    // enable drop at bit 2 held: stop at the frame wrap with no frame_start
    run_cycles(8);
    enable = 1'b0;
    run_cycles(FRAME - 8);
    idle_cycles(6);
    enable = 1'b1;
    k_run = 0;
    run_cycles(FRAME + 5);
    $display("phase graceful_stop: checks=%0d", checks);

    // lock loss while bclk is high, then repeat until the counter saturates
    lose_lock();
    check_eq("llc_first", {24'b0, lock_loss_count}, 32'd1);
    for (int i = 1; i < 300; i++) begin
      lock_and_start();
      run_cycles(1);
      lose_lock();
    end
    check_eq("llc_saturated", {24'b0, lock_loss_count}, 32'd255);
    $display("phase lock_loss: checks=%0d", checks);

    // async reset between clock edges while running
    lock_and_start();
    run_cycles(3);
    #2 rst = 1'b1;
    #1 check_eq("async_reset", {18'b0, obs_vec()}, 32'd0);
    exp_llc = 8'd0;
    idle_cycles(1);
    rst = 1'b0;
    // restart with a 3-cycle lock glitch while hold_cnt=3: hold restarts, no loss counted
    idle_cycles(4);
    pll_locked = 1'b0;
    idle_cycles(3);
    pll_locked = 1'b1;
    idle_cycles(2 + H);
    k_run = 0;
    run_cycles(FRAME);
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("phase async_reset_glitch: checks=%0d", checks);

    // default parameters: RUN at edge 3+1024, then 10 frames of counts
    rst_d = 1'b0;
    locked_d = 1'b1;
    early = 1'b0;
    for (int i = 1; i <= 1026; i++) begin
      @(negedge clk);
      if (active_d) early = 1'b1;
    end
    check_eq("def_no_early_active", {31'b0, early}, 32'd0);
    @(negedge clk);
    check_eq("def_active_entry", {31'b0, active_d}, 32'd1);
    check_eq("def_fs_entry", {31'b0, fs_d}, 32'd1);
    n_rise = 0; n_fs = 0; n_high = 0; both = 0;
    r1 = -1; r2 = -1; l1 = -1; l2 = -1; fs2 = -1;
    prev_lr = 1'b0;
    for (int k = 0; k < 10 * 2048; k++) begin
      if (k > 0) @(negedge clk);
      if (rise_d) begin
        n_rise++;
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      if (fs_d) begin
        n_fs++;
        if (k > 0 && fs2 < 0) fs2 = k;
      end
      if (lrclk_d && !prev_lr) begin
        if (l1 < 0) l1 = k; else if (l2 < 0) l2 = k;
      end
      prev_lr = lrclk_d;
      if (bclk_d) n_high++;
      if (rise_d && fall_d) both++;
    end
    check_eq("def_rise_count", n_rise, 32'd640);
    check_eq("def_fs_count", n_fs, 32'd10);
    check_eq("def_first_rise", r1, 32'd16);
    check_eq("def_bclk_period", r2 - r1, 32'd32);
    check_eq("def_bclk_high", n_high, 32'd10240);
    check_eq("def_fs_period", fs2, 32'd2048);
    check_eq("def_lrclk_first_rise", l1, 32'd1024);
    check_eq("def_lrclk_period", l2 - l1, 32'd2048);
    check_eq("def_rise_fall_overlap", both, 32'd0);
    check_eq("def_llc", {24'b0, llc_d}, 32'd0);
    $display("phase defaults: checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
